// File: rtl/header_feeder.sv
// Host-side header buffer and byte-request server for the tt_um_bitcoin miner core.
// Optional build macro NONCE_AUTOINC_EN: bump the little-endian nonce when a job completes.
module header_feeder #(
  parameter int HDR_BYTES  = 80,
  parameter int HASH_BYTES = 32,
  parameter int NONCE_OFS  = 76
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    load_valid,
  input  logic [7:0]              load_data,
  output logic                    load_ready,
  input  logic                    go,
  output logic                    busy,
  output logic                    miner_start,
  input  logic                    miner_rq,
  input  logic                    miner_done,
  input  logic [7:0]              miner_addr,
  output logic [7:0]              miner_data,
  output logic                    miner_rdy,
  output logic [HASH_BYTES*8-1:0] digest,
  output logic                    digest_valid,
  output logic                    addr_err
);

  localparam int ADDR_W = $clog2(HDR_BYTES);
  localparam int CNT_W  = $clog2(HASH_BYTES + 1);
  localparam logic [7:0]        ADDR_LIMIT = 8'(HDR_BYTES);
  localparam logic [ADDR_W-1:0] LAST_LOAD  = ADDR_W'(HDR_BYTES - 1);
  localparam logic [CNT_W-1:0]  LAST_BYTE  = CNT_W'(HASH_BYTES - 1);

`ifdef NONCE_AUTOINC_EN
  localparam bit NONCE_INC = 1'b1;
`else
  localparam bit NONCE_INC = 1'b0;
`endif

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_SERVE,
    S_COLLECT,
    S_DONE
  } state_t;

  state_t            state, state_n;
  logic [7:0]        hdr_mem [HDR_BYTES];
  logic [ADDR_W-1:0] load_ptr;
  logic              header_loaded;
  logic              rq_q;
  logic              start_cnt;
  logic [CNT_W-1:0]  byte_cnt;
  logic [31:0]       nonce;

  logic req_ev, load_we, accept_go, do_serve, do_collect, do_ack, enter_done;

  assign req_ev      = miner_rq & ~rq_q;
  assign load_ready  = (state == S_IDLE);
  assign busy        = (state != S_IDLE);
  assign miner_start = (state == S_START);
  assign load_we     = load_ready & load_valid;
  assign nonce       = {hdr_mem[NONCE_OFS+3], hdr_mem[NONCE_OFS+2],
                        hdr_mem[NONCE_OFS+1], hdr_mem[NONCE_OFS]};

  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_n;
  end

  // NOTE: every output of this block gets a default first, so no path can infer a latch.
  always_comb begin
    state_n    = state;
    accept_go  = 1'b0;
    do_serve   = 1'b0;
    do_collect = 1'b0;
    do_ack     = 1'b0;
    enter_done = 1'b0;
    case (state)
      S_IDLE: begin
        if (go && header_loaded) begin
          accept_go = 1'b1;
          state_n   = S_START;
        end
      end
      S_START: begin
        if (start_cnt) state_n = S_SERVE;
      end
      S_SERVE, S_COLLECT: begin
        if (req_ev) begin
          do_ack = 1'b1;
          if (miner_done) begin
            do_collect = 1'b1;
            if (byte_cnt == LAST_BYTE) begin
              enter_done = 1'b1;
              state_n    = S_DONE;
            end else begin
              state_n = S_COLLECT;
            end
          end else begin
            do_serve = 1'b1;
          end
        end
      end
      S_DONE: begin
        do_ack = req_ev;
        if (!miner_done) state_n = S_IDLE;
      end
      default: state_n = S_IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      rq_q          <= 1'b0;
      start_cnt     <= 1'b0;
      load_ptr      <= '0;
      header_loaded <= 1'b0;
      miner_rdy     <= 1'b0;
      miner_data    <= 8'h00;
      addr_err      <= 1'b0;
      digest        <= '0;
      digest_valid  <= 1'b0;
      byte_cnt      <= '0;
    end else begin
      rq_q      <= miner_rq;
      miner_rdy <= do_ack;
      start_cnt <= (state == S_START) ? ~start_cnt : 1'b0;

      if (load_we) begin
        if (load_ptr == LAST_LOAD) begin
          load_ptr      <= '0;
          header_loaded <= 1'b1;
        end else begin
          load_ptr <= load_ptr + 1'b1;
        end
      end

      if (accept_go) begin
        digest_valid <= 1'b0;
        addr_err     <= 1'b0;
        byte_cnt     <= '0;
        digest       <= '0;
      end

      if (do_serve) begin
        if (miner_addr < ADDR_LIMIT) begin
          miner_data <= hdr_mem[miner_addr[ADDR_W-1:0]];
        end else begin
          miner_data <= 8'h00;
          addr_err   <= 1'b1;
        end
      end

      // Digest bytes arrive MSB-first: byte i lands in the i-th byte lane from the top.
      if (do_collect) begin
        for (int k = 0; k < HASH_BYTES; k++) begin
          if (byte_cnt == CNT_W'(k)) digest[8*(HASH_BYTES-1-k) +: 8] <= miner_addr;
        end
        byte_cnt <= byte_cnt + 1'b1;
      end

      if (enter_done) digest_valid <= 1'b1;
    end
  end

  // NOTE: the header buffer has a reset so unloaded bytes read as 0x00; this keeps it in flops, not RAM.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < HDR_BYTES; k++) hdr_mem[k] <= 8'h00;
    end else if (load_we) begin
      hdr_mem[load_ptr] <= load_data;
    end else if (NONCE_INC && enter_done) begin
      {hdr_mem[NONCE_OFS+3], hdr_mem[NONCE_OFS+2],
       hdr_mem[NONCE_OFS+1], hdr_mem[NONCE_OFS]} <= nonce + 32'd1;
    end
  end

endmodule

// File: tb/tb_header_feeder.sv
// Directed bench for header_feeder: a header/request model checks every miner_rdy/miner_data
// cycle while literal expectations pin the genesis bytes, digest and nonce behaviour.
module tb_header_feeder;

  logic         clk = 1'b0;
  logic         rst, load_valid, go, miner_rq, miner_done;
  logic [7:0]   load_data, miner_addr;
  logic         load_ready, busy, miner_start, miner_rdy, digest_valid, addr_err;
  logic [7:0]   miner_data;
  logic [255:0] digest;

  int n_run  = 0;
  int n_fail = 0;

  logic [7:0]   hdr_model [80];
  logic [7:0]   hdr_stage [80];
  logic [255:0] digest_model;
  logic [7:0]   exp_data = 8'h00;
  logic         exp_rdy  = 1'b0;
  logic         rq_last  = 1'b0;
  logic         mon_en   = 1'b0;

  always #5 clk = ~clk;

  header_feeder dut (
    .clk          (clk),
    .rst          (rst),
    .load_valid   (load_valid),
    .load_data    (load_data),
    .load_ready   (load_ready),
    .go           (go),
    .busy         (busy),
    .miner_start  (miner_start),
    .miner_rq     (miner_rq),
    .miner_done   (miner_done),
    .miner_addr   (miner_addr),
    .miner_data   (miner_data),
    .miner_rdy    (miner_rdy),
    .digest       (digest),
    .digest_valid (digest_valid),
    .addr_err     (addr_err)
  );

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
    n_run++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: a request is a rising rq; its acknowledge appears exactly one cycle later.
  always @(negedge clk) begin
    if (mon_en) begin
      check("rdy_pulse", 256'(miner_rdy), 256'(exp_rdy));
      if (exp_rdy) check("rdy_data", 256'(miner_data), 256'(exp_data));
    end
    exp_rdy = mon_en && !rst && miner_rq && !rq_last;
    if (exp_rdy && !miner_done)
      exp_data = (miner_addr < 8'd80) ? hdr_model[miner_addr] : 8'h00;
    rq_last = rst ? 1'b0 : miner_rq;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    mon_en = 1'b0;
    rst = 1'b1;
    tick;
    tick;
    rst = 1'b0;
    exp_data = 8'h00;
    for (int i = 0; i < 80; i++) hdr_model[i] = 8'h00;
  endtask

  task automatic load_stage;
    tick;
    for (int i = 0; i < 80; i++) begin
      load_valid = 1'b1;
      load_data  = hdr_stage[i];
      hdr_model[i] = hdr_stage[i];
      tick;
    end
    load_valid = 1'b0;
  endtask

  task automatic start_job;
    tick;
    go = 1'b1;
    tick;
    go = 1'b0;
    mon_en = 1'b1;
    digest_model = '0;
    @(negedge clk);
    check("start_c1", 256'(miner_start), 256'(1));
    check("busy_start", 256'(busy), 256'(1));
    check("dv_cleared", 256'(digest_valid), 256'(0));
    check("err_cleared", 256'(addr_err), 256'(0));
    tick;
    @(negedge clk);
    check("start_c2", 256'(miner_start), 256'(1));
    tick;
    @(negedge clk);
    check("start_end", 256'(miner_start), 256'(0));
    check("load_ready_busy", 256'(load_ready), 256'(0));
  endtask

  task automatic request(input logic [7:0] addr, input logic done);
    tick;
    miner_addr = addr;
    miner_done = done;
    miner_rq   = 1'b1;
    tick;
    miner_rq = 1'b0;
    @(negedge clk);
  endtask

  task automatic collect_bytes(input logic [7:0] base, input int count);
    for (int k = 0; k < count; k++) begin
      request(8'(base + k), 1'b1);
      digest_model[255-8*k -: 8] = 8'(base + k);
    end
  endtask

  task automatic finish_job;
    logic [31:0] n;
    tick;
    miner_done = 1'b0;
    tick;
    @(negedge clk);
    check("busy_after_done", 256'(busy), 256'(0));
    check("load_ready_idle", 256'(load_ready), 256'(1));
    mon_en = 1'b0;
`ifdef NONCE_AUTOINC_EN
    n = {hdr_model[79], hdr_model[78], hdr_model[77], hdr_model[76]} + 32'd1;
    {hdr_model[79], hdr_model[78], hdr_model[77], hdr_model[76]} = n;
`else
    n = '0;
`endif
  endtask

  task automatic stage_genesis;
    for (int i = 0; i < 80; i++) hdr_stage[i] = 8'(i * 7 + 3);
    hdr_stage[0]  = 8'h01;
    hdr_stage[68] = 8'h29; hdr_stage[69] = 8'hAB; hdr_stage[70] = 8'h5F; hdr_stage[71] = 8'h49;
    hdr_stage[72] = 8'hFF; hdr_stage[73] = 8'hFF; hdr_stage[74] = 8'h00; hdr_stage[75] = 8'h1D;
    hdr_stage[76] = 8'h1D; hdr_stage[77] = 8'hAC; hdr_stage[78] = 8'h2B; hdr_stage[79] = 8'h7C;
  endtask

  initial begin
    logic [7:0] nonce_lsb_exp, wrap_exp;
    int pulses;
`ifdef NONCE_AUTOINC_EN
    nonce_lsb_exp = 8'h1E;
    wrap_exp      = 8'h00;
`else
    nonce_lsb_exp = 8'h1D;
    wrap_exp      = 8'hFF;
`endif
    rst = 1'b1; load_valid = 1'b0; load_data = 8'h00; go = 1'b0;
    miner_rq = 1'b0; miner_done = 1'b0; miner_addr = 8'h00;
    do_reset;
    @(negedge clk);
    check("rst_busy", 256'(busy), 256'(0));
    check("rst_load_ready", 256'(load_ready), 256'(1));
    check("rst_start", 256'(miner_start), 256'(0));
    check("rst_rdy", 256'(miner_rdy), 256'(0));
    check("rst_dv", 256'(digest_valid), 256'(0));
    check("rst_err", 256'(addr_err), 256'(0));
    check("rst_data", 256'(miner_data), 256'(0));
    check("rst_digest", digest, 256'(0));

    // go before any header load must be ignored
    tick; go = 1'b1; tick; go = 1'b0;
    @(negedge clk);
    check("go_unloaded_busy", 256'(busy), 256'(0));

    stage_genesis;
    load_stage;
    start_job;

    request(8'd0, 1'b0);
    check("addr0_data", 256'(miner_data), 256'(8'h01));
    check("addr0_rdy", 256'(miner_rdy), 256'(1));
    request(8'd68, 1'b0);
    check("addr68_data", 256'(miner_data), 256'(8'h29));
    request(8'd79, 1'b0);
    check("addr79_data", 256'(miner_data), 256'(8'h7C));
    check("addr79_err", 256'(addr_err), 256'(0));
    request(8'd90, 1'b0);
    check("addr90_data", 256'(miner_data), 256'(8'h00));
    check("addr90_err", 256'(addr_err), 256'(1));

    // held rq is a single request
    tick;
    miner_addr = 8'd68; miner_done = 1'b0; miner_rq = 1'b1;
    pulses = 0;
    for (int i = 0; i < 7; i++) begin
      @(negedge clk);
      if (miner_rdy) pulses++;
      tick;
      if (i == 4) miner_rq = 1'b0;
    end
    check("held_rq_pulses", 256'(pulses), 256'(1));

    // host writes while busy must not reach the buffer
    load_valid = 1'b1; load_data = 8'hEE;
    tick; tick; tick;
    load_valid = 1'b0;
    request(8'd0, 1'b0);
    check("busy_load_ignored", 256'(miner_data), 256'(8'h01));

    collect_bytes(8'hA0, 32);
    check("digest_lit", digest,
          256'hA0A1A2A3A4A5A6A7A8A9AAABACADAEAFB0B1B2B3B4B5B6B7B8B9BABBBCBDBEBF);
    check("digest_model", digest, digest_model);
    check("digest_valid", 256'(digest_valid), 256'(1));
    check("busy_done", 256'(busy), 256'(1));
    request(8'h55, 1'b1);
    check("done_extra_rdy", 256'(miner_rdy), 256'(1));
    check("done_extra_nostore", digest, digest_model);
    finish_job;
    check("dv_hold", 256'(digest_valid), 256'(1));

    // second job without reload: nonce bumped only with the autoinc build
    start_job;
    request(8'd0, 1'b0);
    check("job2_addr0", 256'(miner_data), 256'(8'h01));
    request(8'd76, 1'b0);
    check("job2_nonce_lsb", 256'(miner_data), 256'(nonce_lsb_exp));
    collect_bytes(8'hC0, 10);
    check("partial_dv", 256'(digest_valid), 256'(0));
    mon_en = 1'b0;
    tick;
    rst = 1'b1; miner_done = 1'b0;
    tick;
    @(negedge clk);
    check("midrst_busy", 256'(busy), 256'(0));
    check("midrst_digest", digest, 256'(0));
    check("midrst_dv", 256'(digest_valid), 256'(0));
    check("midrst_rdy", 256'(miner_rdy), 256'(0));
    tick;
    rst = 1'b0;
    exp_data = 8'h00;
    for (int i = 0; i < 80; i++) hdr_model[i] = 8'h00;
    go = 1'b1; tick; go = 1'b0;
    @(negedge clk);
    check("go_after_rst_busy", 256'(busy), 256'(0));
    check("go_after_rst_start", 256'(miner_start), 256'(0));

    // nonce wrap 0xFFFFFFFF -> 0
    stage_genesis;
    for (int i = 76; i < 80; i++) hdr_stage[i] = 8'hFF;
    load_stage;
    start_job;
    request(8'd76, 1'b0);
    check("wrap_pre", 256'(miner_data), 256'(8'hFF));
    collect_bytes(8'h10, 32);
    check("wrap_digest", digest, digest_model);
    finish_job;
    start_job;
    for (int i = 76; i < 80; i++) begin
      request(8'(i), 1'b0);
      check("wrap_post", 256'(miner_data), 256'(wrap_exp));
    end
    mon_en = 1'b0;

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
